// File: rtl/vram_pkg.sv
// vram_pkg: frame-buffer geometry, coordinate/pixel types and the arbiter state
// encoding shared by vram_arbiter and its line buffer.
package vram_pkg;

    localparam int unsigned H_PIXELS = 128;
    localparam int unsigned V_LINES  = 64;
    localparam int unsigned PIX_W    = 2;
    localparam int unsigned HPOS_W   = $clog2(H_PIXELS);
    localparam int unsigned VPOS_W   = $clog2(V_LINES);

    typedef logic [HPOS_W-1:0] hpos_t;
    typedef logic [VPOS_W-1:0] vpos_t;
    typedef logic [PIX_W-1:0]  pixel_t;

    localparam hpos_t HPOS_LAST = hpos_t'(H_PIXELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_WR,
        ST_CPU_RD,
        ST_CPU_RMW,
        ST_LINE_FETCH,
        ST_LINE_DRAIN
    } arb_state_t;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: two H_PIXELS-deep pixel banks; the fetch writes the back bank while
// scanout reads the front bank through a registered port. bank_sel names the front bank.
module line_buffer
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bank_sel,
    input  logic              wr_en,
    input  logic [HPOS_W-1:0] wr_hpos,
    input  logic [PIX_W-1:0]  wr_pixel,
    input  logic [HPOS_W-1:0] rd_hpos,
    output logic [PIX_W-1:0]  rd_pixel
);

    pixel_t bank0_q [H_PIXELS];
    pixel_t bank1_q [H_PIXELS];
    pixel_t rd_pixel_q;

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (bank_sel) begin
                bank0_q[wr_hpos] <= wr_pixel;
            end else begin
                bank1_q[wr_hpos] <= wr_pixel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pixel_q <= '0;
        end else begin
            rd_pixel_q <= bank_sel ? bank1_q[rd_hpos] : bank0_q[rd_hpos];
        end
    end

    assign rd_pixel = rd_pixel_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between CPU pixel writes and scanout
// line prefetch. Define VRAM_XOR_EN for XOR-draw (read-modify-write) with collision flag.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [HPOS_W-1:0] cpu_hpos,
    input  logic [VPOS_W-1:0] cpu_vpos,
    input  logic [PIX_W-1:0]  cpu_pixel,
    output logic              cpu_ack,
    output logic              cpu_collision,
    input  logic              cpu_collision_clr,
    input  logic              line_req,
    input  logic [VPOS_W-1:0] line_vpos,
    output logic              line_busy,
    output logic              line_done,
    input  logic [HPOS_W-1:0] lb_rd_hpos,
    output logic [PIX_W-1:0]  lb_rd_pixel,
    output logic [HPOS_W-1:0] vram_hpos,
    output logic [VPOS_W-1:0] vram_vpos,
    output logic [PIX_W-1:0]  vram_pixeli,
    input  logic [PIX_W-1:0]  vram_pixelo,
    output logic              vram_we
);

    arb_state_t state_q;
    hpos_t      vram_hpos_q;
    vpos_t      vram_vpos_q;
    pixel_t     vram_pixeli_q;
    logic       vram_we_q;
    logic       cpu_ack_q;
    logic       line_pend_q;
    vpos_t      line_vpos_q;
    logic       line_done_q;
    logic       bank_sel_q;

    logic       line_accept;
    logic       lb_wr_en;
    hpos_t      lb_wr_hpos;

    assign line_accept = line_req && !line_pend_q;

    // Read data trails the address by one cycle, so each fetch cycle stores the
    // previous column; the drain cycle stores the last one.
    assign lb_wr_en   = ((state_q == ST_LINE_FETCH) && (vram_hpos_q != '0)) ||
                        (state_q == ST_LINE_DRAIN);
    assign lb_wr_hpos = (state_q == ST_LINE_DRAIN) ? HPOS_LAST : (vram_hpos_q - hpos_t'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vram_hpos_q   <= '0;
            vram_vpos_q   <= '0;
            vram_pixeli_q <= '0;
            vram_we_q     <= 1'b0;
            cpu_ack_q     <= 1'b0;
            line_pend_q   <= 1'b0;
            line_vpos_q   <= '0;
            line_done_q   <= 1'b0;
            bank_sel_q    <= 1'b0;
        end else begin
            cpu_ack_q   <= 1'b0;
            line_done_q <= 1'b0;

            if (line_accept) begin
                line_pend_q <= 1'b1;
                line_vpos_q <= line_vpos;
            end

            case (state_q)
                ST_IDLE: begin
                    // A request arriving this very cycle already beats the CPU.
                    if (line_pend_q || line_req) begin
                        state_q     <= ST_LINE_FETCH;
                        vram_hpos_q <= '0;
                        vram_vpos_q <= line_pend_q ? line_vpos_q : line_vpos;
                        vram_we_q   <= 1'b0;
                    end else if (cpu_req) begin
                        vram_hpos_q   <= cpu_hpos;
                        vram_vpos_q   <= cpu_vpos;
                        vram_pixeli_q <= cpu_pixel;
`ifdef VRAM_XOR_EN
                        state_q       <= ST_CPU_RD;
                        vram_we_q     <= 1'b0;
`else
                        state_q       <= ST_CPU_WR;
                        vram_we_q     <= 1'b1;
                        cpu_ack_q     <= 1'b1;
`endif
                    end
                end
                ST_CPU_WR: begin
                    state_q   <= ST_IDLE;
                    vram_we_q <= 1'b0;
                end
`ifdef VRAM_XOR_EN
                ST_CPU_RD: begin
                    state_q   <= ST_CPU_RMW;
                    vram_we_q <= 1'b1;
                    cpu_ack_q <= 1'b1;
                end
                ST_CPU_RMW: begin
                    state_q   <= ST_IDLE;
                    vram_we_q <= 1'b0;
                end
`endif
                ST_LINE_FETCH: begin
                    if (vram_hpos_q == HPOS_LAST) begin
                        state_q <= ST_LINE_DRAIN;
                    end else begin
                        vram_hpos_q <= vram_hpos_q + hpos_t'(1);
                    end
                end
                ST_LINE_DRAIN: begin
                    state_q     <= ST_IDLE;
                    bank_sel_q  <= ~bank_sel_q;
                    line_pend_q <= 1'b0;
                    line_done_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    vram_we_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef VRAM_XOR_EN
    logic collision_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else if ((state_q == ST_CPU_RMW) && (vram_pixelo != '0) && (vram_pixeli_q != '0)) begin
            collision_q <= 1'b1;
        end else if (cpu_collision_clr) begin
            collision_q <= 1'b0;
        end
    end

    // RAM read data only exists during the RMW cycle, so the XOR is applied on the way out.
    assign vram_pixeli   = (state_q == ST_CPU_RMW) ? (vram_pixelo ^ vram_pixeli_q) : vram_pixeli_q;
    assign cpu_collision = collision_q;
`else
    logic unused_collision_clr;
    assign unused_collision_clr = cpu_collision_clr;
    assign vram_pixeli          = vram_pixeli_q;
    assign cpu_collision        = 1'b0;
`endif

    assign vram_hpos = vram_hpos_q;
    assign vram_vpos = vram_vpos_q;
    assign vram_we   = vram_we_q;
    assign cpu_ack   = cpu_ack_q;
    assign line_busy = line_pend_q;
    assign line_done = line_done_q;

    line_buffer u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .bank_sel (bank_sel_q),
        .wr_en    (lb_wr_en),
        .wr_hpos  (lb_wr_hpos),
        .wr_pixel (vram_pixelo),
        .rd_hpos  (lb_rd_hpos),
        .rd_pixel (lb_rd_pixel)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural VRAM, a
// frame-level reference image and a monitor that checks writes and scanout reads.
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_pkg::*;

    typedef struct packed {
        logic [6:0] h;
        logic [5:0] v;
        logic [1:0] p;
    } wr_t;
    typedef logic [255:0] line_t;

`ifdef VRAM_XOR_EN
    localparam int CPU_LAT = 2;
`else
    localparam int CPU_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic [6:0] cpu_hpos = '0;
    logic [5:0] cpu_vpos = '0;
    logic [1:0] cpu_pixel = '0;
    logic       cpu_ack;
    logic       cpu_collision;
    logic       cpu_collision_clr = 1'b0;
    logic       line_req = 1'b0;
    logic [5:0] line_vpos = '0;
    logic       line_busy;
    logic       line_done;
    logic [6:0] lb_rd_hpos = '0;
    logic [1:0] lb_rd_pixel;
    logic [6:0] vram_hpos;
    logic [5:0] vram_vpos;
    logic [1:0] vram_pixeli;
    logic [1:0] vram_pixelo = '0;
    logic       vram_we;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cpu_req           (cpu_req),
        .cpu_hpos          (cpu_hpos),
        .cpu_vpos          (cpu_vpos),
        .cpu_pixel         (cpu_pixel),
        .cpu_ack           (cpu_ack),
        .cpu_collision     (cpu_collision),
        .cpu_collision_clr (cpu_collision_clr),
        .line_req          (line_req),
        .line_vpos         (line_vpos),
        .line_busy         (line_busy),
        .line_done         (line_done),
        .lb_rd_hpos        (lb_rd_hpos),
        .lb_rd_pixel       (lb_rd_pixel),
        .vram_hpos         (vram_hpos),
        .vram_vpos         (vram_vpos),
        .vram_pixeli       (vram_pixeli),
        .vram_pixelo       (vram_pixelo),
        .vram_we           (vram_we)
    );

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int lines_issued = 0;
    int busy_cnt = 0;
    int last_busy = 0;
    bit rd_sweep = 1'b0;

    logic [1:0] ref_mem [64][128];
    logic [1:0] vram    [64][128];
    bit         vram_loaded = 1'b0;
    wr_t        exp_wr_q [$];
    line_t      exp_line_q [$];

    // External single-port RAM: synchronous read, read-before-write.
    always @(posedge clk) begin
        if (!vram_loaded) begin
            for (int v = 0; v < 64; v++)
                for (int h = 0; h < 128; h++)
                    vram[v][h] <= ref_mem[v][h];
            vram_loaded <= 1'b1;
        end else begin
            vram_pixelo <= vram[vram_vpos][vram_hpos];
            if (vram_we) vram[vram_vpos][vram_hpos] <= vram_pixeli;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_ack"},       32'(cpu_ack),       32'd0);
        chk({tag, "_cpu_collision"}, 32'(cpu_collision), 32'd0);
        chk({tag, "_line_busy"},     32'(line_busy),     32'd0);
        chk({tag, "_line_done"},     32'(line_done),     32'd0);
        chk({tag, "_lb_rd_pixel"},   32'(lb_rd_pixel),   32'd0);
        chk({tag, "_vram_hpos"},     32'(vram_hpos),     32'd0);
        chk({tag, "_vram_vpos"},     32'(vram_vpos),     32'd0);
        chk({tag, "_vram_pixeli"},   32'(vram_pixeli),   32'd0);
        chk({tag, "_vram_we"},       32'(vram_we),       32'd0);
    endtask

    // Reference image: lines are snapshotted at request time, writes applied in order.
    task automatic push_line(input int lv);
        line_t s;
        for (int h = 0; h < 128; h++) s[2*h +: 2] = ref_mem[lv][h];
        exp_line_q.push_back(s);
    endtask

    task automatic push_wr(input int h, input int v, input int p);
        wr_t e;
        e.h = 7'(h);
        e.v = 6'(v);
`ifdef VRAM_XOR_EN
        e.p = ref_mem[v][h] ^ 2'(p);
`else
        e.p = 2'(p);
`endif
        ref_mem[v][h] = e.p;
        exp_wr_q.push_back(e);
    endtask

    task automatic issue(input bit do_line, input int lv, input bit do_cpu,
                         input int h, input int v, input int p, output int lat);
        lat = 0;
        if (do_line) begin
            push_line(lv);
            line_vpos = 6'(lv);
            line_req = 1'b1;
            lines_issued++;
        end
        if (do_cpu) begin
            push_wr(h, v, p);
            cpu_hpos = 7'(h);
            cpu_vpos = 6'(v);
            cpu_pixel = 2'(p);
            cpu_req = 1'b1;
        end
        do begin
            @(posedge clk); #1;
            line_req = 1'b0;
            lat++;
        end while (do_cpu && !cpu_ack && lat < 400);
        if (do_cpu) begin
            if (!cpu_ack) chk("cpu_ack_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            cpu_req = 1'b0;
        end
    endtask

    task automatic wait_lines();
        int n = 0;
        while (done_cnt != lines_issued && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt != lines_issued) chk("line_done_timeout", 32'(done_cnt), 32'(lines_issued));
    endtask

    initial begin : rd_driver
        forever begin
            @(posedge clk); #1;
            lb_rd_hpos = rd_sweep ? lb_rd_hpos + 7'd1 : 7'($urandom_range(0, 127));
        end
    end

    initial begin : monitor
        wr_t        e;
        line_t      front_exp = '0;
        bit         front_valid = 1'b0;
        logic [6:0] rd_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                front_valid = 1'b0;
                busy_cnt = 0;
            end else begin
                if (cpu_ack) begin
                    if (exp_wr_q.size() == 0) begin
                        chk("wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("wr_we",     32'(vram_we),     32'd1);
                        chk("wr_hpos",   32'(vram_hpos),   32'(e.h));
                        chk("wr_vpos",   32'(vram_vpos),   32'(e.v));
                        chk("wr_pixeli", 32'(vram_pixeli), 32'(e.p));
                    end
                end else if (vram_we) begin
                    chk("we_without_ack", 32'(vram_we), 32'd0);
                end
                if (front_valid) chk("lb_rd_pixel", 32'(lb_rd_pixel), 32'(front_exp[2*rd_prev +: 2]));
                if (line_busy) busy_cnt++;
                if (line_done) begin
                    done_cnt++;
                    last_busy = busy_cnt;
                    busy_cnt = 0;
                    chk("busy_low_at_done", 32'(line_busy), 32'd0);
                    if (exp_line_q.size() == 0) begin
                        chk("line_done_unexpected", 32'd1, 32'd0);
                    end else begin
                        front_exp = exp_line_q.pop_front();
                        front_valid = 1'b1;
                    end
                end
            end
            rd_prev = lb_rd_hpos;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int n;
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < 128; h++)
                ref_mem[v][h] = 2'($urandom_range(0, 3));
        for (int h = 0; h < 128; h++) ref_mem[10][h] = 2'(h % 4);
        ref_mem[3][3] = 2'd3;
        ref_mem[4][4] = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle write, one-cycle latency
        issue(1'b0, 0, 1'b1, 5, 7, 3, lat);
        chk("idle_latency", 32'(lat), 32'(CPU_LAT));
`ifndef VRAM_XOR_EN
        cpu_collision_clr = 1'b1;
        @(posedge clk); #1;
        cpu_collision_clr = 1'b0;
        chk("collision_tied0", 32'(cpu_collision), 32'd0);
`endif

        // Line 10 prefetch, then sweep the front bank in order
        issue(1'b1, 10, 1'b0, 0, 0, 0, lat);
        wait_lines();
        chk("line10_busy_cycles", 32'(last_busy), 32'd129);
        rd_sweep = 1'b1;
        repeat (140) @(posedge clk);
        #1;
        rd_sweep = 1'b0;

        // Contention: line fetch wins, CPU stalls behind it
        issue(1'b1, 20, 1'b1, 9, 21, 2, lat);
        chk("contention_latency", 32'(lat), 32'(130 + CPU_LAT));
        wait_lines();
        issue(1'b1, 21, 1'b0, 0, 0, 0, lat);
        wait_lines();

        // Second line_req while busy is dropped
        issue(1'b1, 30, 1'b0, 0, 0, 0, lat);
        repeat (20) @(posedge clk);
        #1;
        line_vpos = 6'd31;
        line_req = 1'b1;
        @(posedge clk); #1;
        line_req = 1'b0;
        chk("busy_held", 32'(line_busy), 32'd1);
        wait_lines();
        chk("busy_line_cycles", 32'(last_busy), 32'd129);
        repeat (150) @(posedge clk);
        #1;
        chk("single_line_done", 32'(done_cnt), 32'(lines_issued));

        // Reset in the middle of a fetch
        issue(1'b1, 12, 1'b0, 0, 0, 0, lat);
        n = 0;
        while (!(vram_hpos == 7'd60 && line_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_hpos60", 32'(vram_hpos), 32'd60);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid");
        exp_line_q.delete();
        lines_issued = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (160) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'(done_cnt), 32'(lines_issued));
        issue(1'b1, 12, 1'b0, 0, 0, 0, lat);
        wait_lines();
        chk("post_reset_busy_cycles", 32'(last_busy), 32'd129);

`ifdef VRAM_XOR_EN
        issue(1'b0, 0, 1'b1, 3, 3, 3, lat);
        chk("xor_collision_set", 32'(cpu_collision), 32'd1);
        cpu_collision_clr = 1'b1;
        @(posedge clk); #1;
        cpu_collision_clr = 1'b0;
        chk("xor_collision_clr", 32'(cpu_collision), 32'd0);
        issue(1'b0, 0, 1'b1, 4, 4, 3, lat);
        chk("xor_no_collision", 32'(cpu_collision), 32'd0);
`endif

        // Randomised mix of writes and fetches over a small window of lines
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                issue(1'b1, 32'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 127)), 32'($urandom_range(0, 7)),
                      32'($urandom_range(0, 3)), lat);
                wait_lines();
            end else begin
                issue(1'b0, 0, 1'b1, 32'($urandom_range(0, 127)), 32'($urandom_range(0, 7)),
                      32'($urandom_range(0, 3)), lat);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("wr_queue_empty",   32'(exp_wr_q.size()),   32'd0);
        chk("line_queue_empty", 32'(exp_line_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 128x64x2-bit video RAM between two requesters: the CHIP-8 CPU's clear/draw pixel writes and the display scanout's line prefetch. Sits between the CPU's vram_* port and the frame buffer. Fetches one display line at a time into a double-banked line buffer so scanout never touches VRAM directly. Serialises CPU writes with a handshake that stalls the CPU while a line fetch owns the RAM.

## Interface
- H_PIXELS, 128, pixels per line; sets hpos width (7)
- V_LINES, 64, lines per frame; sets vpos width (6)
- PIX_W, 2, bits per pixel

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU write request; level, held until cpu_ack
- cpu_hpos  in  7  CPU pixel x
- cpu_vpos  in  6  CPU pixel y
- cpu_pixel  in  2  CPU pixel value
- cpu_ack  out  1  one-cycle pulse, write committed this cycle
- cpu_collision  out  1  sticky collision flag (VRAM_XOR_EN only; else 0)
- cpu_collision_clr  in  1  clears cpu_collision
- line_req  in  1  one-cycle pulse, fetch line line_vpos
- line_vpos  in  6  line to fetch
- line_busy  out  1  fetch accepted/pending, not yet done
- line_done  out  1  one-cycle pulse, new line now in front bank
- lb_rd_hpos  in  7  scanout read address, front bank
- lb_rd_pixel  out  2  front-bank pixel, registered, 1-cycle latency
- vram_hpos  out  7  VRAM address x, registered
- vram_vpos  out  6  VRAM address y, registered
- vram_pixeli  out  2  VRAM write data, registered
- vram_pixelo  in  2  VRAM read data, valid 1 cycle after address
- vram_we  out  1  VRAM write enable, registered

## Operation
- States: IDLE, CPU_WR, CPU_RD, CPU_RMW, LINE_FETCH, LINE_DRAIN.
- IDLE: if line pending -> LINE_FETCH; else if cpu_req -> CPU_WR (CPU_RD with VRAM_XOR_EN); else stay.
- line_req in any state with line_busy=0: latch line_vpos, set pending, line_busy=1. line_req while line_busy=1 ignored.
- CPU_WR: vram_we=1, address/data from cpu_*, cpu_ack=1; -> IDLE.
- CPU_RD: address presented, vram_we=0; -> CPU_RMW.
- CPU_RMW: vram_pixeli = vram_pixelo ^ cpu_pixel, vram_we=1, cpu_ack=1; collision set if vram_pixelo!=0 and cpu_pixel!=0; -> IDLE.
- LINE_FETCH: hpos counter 0..127, one read per cycle, vpos = latched line; data captured next cycle into back bank at previous hpos; at hpos=127 -> LINE_DRAIN.
- LINE_DRAIN: capture hpos 127, swap banks at end of cycle, clear pending; -> IDLE; line_done=1 next cycle, line_busy drops same cycle.
- CPU ops are non-preemptive; line fetch is non-preemptive.
- Simultaneous cpu_req and pending line in IDLE: line wins, CPU waits (worst-case stall 131 cycles).
- collision_clr and collision set same cycle: set wins.
- Reset (any state, mid-fetch included): state IDLE, all outputs 0, pending cleared, bank select 0, hpos counter 0, collision 0. Line buffer storage not reset.

## Timing
- CPU write latency: req high in IDLE cycle N -> vram_we/cpu_ack in N+1 (N+2 with XOR). Throughput 1 write/2 cycles (1/3 with XOR).
- Requester may present next request the cycle after ack; sampled in the following IDLE cycle.
- Line fetch: accept -> LINE_FETCH next IDLE cycle; 128 fetch + 1 drain cycles; line_done one cycle after drain.
- lb_rd_pixel reflects front bank at lb_rd_hpos from previous cycle; bank swap visible to reads issued after the swap edge.
- hpos counter 7-bit, terminal at 127, no wrap past it.

## Configuration
- VRAM_XOR_EN defined: CPU writes are read-modify-write XOR (CPU_RD/CPU_RMW), cpu_collision active.
- Undefined: CPU_RD/CPU_RMW absent, writes are plain overwrite via CPU_WR, cpu_collision tied 0, cpu_collision_clr ignored.

## Structure
- Shared package vram_pkg: H_PIXELS/V_LINES/PIX_W constants, hpos/vpos/pixel typedefs, arbiter state enum.
- Sub-module line_buffer: two 128x2 banks, one write port (back bank), one registered read port (front bank), bank-select input.

## Test plan
- Idle write: cpu_req, (5,7), pixel 3 -> vram_we=1, hpos 5, vpos 7, pixeli 3, cpu_ack, all 1 cycle after req.
- Line fetch: preload line 10 with hpos%4; line_req vpos 10 -> 129 busy cycles, line_done pulse, lb_rd_hpos 0..127 returns 0,1,2,3,...
- Contention: line_req and cpu_req same cycle -> fetch first, cpu_ack 131 cycles later, write lands at correct address.
- XOR (VRAM_XOR_EN): pixel (3,3)=3, write 3 -> pixeli 0, collision=1; clr -> 0; write 3 to 0-pixel -> pixeli 3, collision 0.
- Reset mid-fetch at hpos 60 -> all outputs 0, line_busy 0, no line_done; new line_req completes normally.
- Busy line_req: second line_req during fetch -> ignored, exactly one line_done.
